// File: rtl/mem_stage_pkg.sv
// Shared types for the memory stage: FSM state encoding and the M->W pipeline bundle.
// The bundle widths below are the reference widths used by memory_stage.
package mem_stage_pkg;

    localparam int MS_DATA_W = 32;
    localparam int MS_WA_W   = 3;

    typedef enum logic {
        IDLE,
        WAIT
    } mstate_t;

    typedef struct packed {
        logic                 pcsrc;
        logic                 regwrite;
        logic                 memtoreg;
        logic                 memerr;
        logic [MS_WA_W-1:0]   wa3;
        logic [MS_DATA_W-1:0] aluout;
        logic [MS_DATA_W-1:0] readdata;
    } mw_t;

    localparam mw_t MW_BUBBLE = '0;

endpackage

// File: rtl/memory_stage_regmw.sv
// M->W pipeline register. Loads every cycle; a bubble zeroes the bundle except for
// the error flag, which lets an aborted access report itself without a writeback.
module RegMW
    import mem_stage_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic bubble,
    input  logic err,
    input  mw_t  d,
    output mw_t  q
);

    mw_t nxt;

    always_comb begin
        nxt = d;
        if (bubble) begin
            nxt        = MW_BUBBLE;
            nxt.memerr = err;
        end
    end

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= MW_BUBBLE;
        end else begin
            q <= nxt;
        end
    end

endmodule

// File: rtl/memory_stage.sv
// Memory stage: req/ready data-memory handshake, pipeline freeze, M->W register.
// Optional macro MEM_TIMEOUT_EN aborts an access after TIMEOUT_CYC request cycles.
module memory_stage
    import mem_stage_pkg::*;
#(
    parameter int DATA_W      = MS_DATA_W,
    parameter int WA_W        = MS_WA_W,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              PCSrcM,
    input  logic              RegWriteM,
    input  logic              MemWriteM,
    input  logic              MemtoRegM,
    input  logic [DATA_W-1:0] ALUResultM,
    input  logic [DATA_W-1:0] WriteDataM,
    input  logic [WA_W-1:0]   WA3M,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              StallM,
    output logic [DATA_W-1:0] ALUResultMFB,
    output logic              PCSrcW,
    output logic              RegWriteW,
    output logic              MemtoRegW,
    output logic [DATA_W-1:0] ReadDataW,
    output logic [DATA_W-1:0] ALUOutW,
    output logic [WA_W-1:0]   WA3W,
    output logic              MemErrW
);

    if (TIMEOUT_CYC < 2) begin : g_bad_timeout
        $error("memory_stage: TIMEOUT_CYC must be at least 2");
    end

    mstate_t state, state_nxt;
    logic    mem_op;
    logic    is_load;
    logic    bubble;
    logic    abort;
    logic    timeout;
    logic    rd_valid;
    mw_t     mw_d;
    mw_t     mw_q;

    // A store wins when both MemWriteM and MemtoRegM are set.
    assign mem_op  = MemWriteM | MemtoRegM;
    assign is_load = MemtoRegM & ~MemWriteM;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC - 1) : 1;

    logic [CNT_W-1:0] wait_cnt;

    // Abort in the WAIT cycle whose increment would reach TIMEOUT_CYC-1; ready still wins.
    assign timeout = (state == WAIT) && !mem_ready && (wait_cnt == CNT_W'(TIMEOUT_CYC - 2));

    always_ff @(posedge clk) begin
        if (reset || state == IDLE) begin
            wait_cnt <= '0;
        end else if (!mem_ready) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        mem_req   = 1'b0;
        StallM    = 1'b0;
        bubble    = 1'b0;
        abort     = 1'b0;
        case (state)
            IDLE: begin
                if (mem_op) begin
                    mem_req = 1'b1;
                    if (!mem_ready) begin
                        StallM    = 1'b1;
                        bubble    = 1'b1;
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    state_nxt = IDLE;
                end else if (timeout) begin
                    bubble    = 1'b1;
                    abort     = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    StallM = 1'b1;
                    bubble = 1'b1;
                end
            end
        endcase
        // Dropping the request under reset abandons any access in flight.
        if (reset) begin
            mem_req = 1'b0;
            StallM  = 1'b0;
        end
    end

    assign mem_we       = mem_req & MemWriteM;
    assign mem_addr     = ALUResultM;
    assign mem_wdata    = WriteDataM;
    assign ALUResultMFB = ALUResultM;
    assign rd_valid     = mem_req & mem_ready & is_load;

    always_comb begin
        mw_d          = MW_BUBBLE;
        mw_d.pcsrc    = PCSrcM;
        mw_d.regwrite = RegWriteM;
        mw_d.memtoreg = is_load;
        mw_d.memerr   = 1'b0;
        mw_d.wa3      = WA3M;
        mw_d.aluout   = ALUResultM;
        mw_d.readdata = rd_valid ? mem_rdata : '0;
    end

    RegMW u_regmw (
        .clk    (clk),
        .reset  (reset),
        .bubble (bubble),
        .err    (abort),
        .d      (mw_d),
        .q      (mw_q)
    );

    assign PCSrcW    = mw_q.pcsrc;
    assign RegWriteW = mw_q.regwrite;
    assign MemtoRegW = mw_q.memtoreg;
    assign MemErrW   = mw_q.memerr;
    assign WA3W      = mw_q.wa3;
    assign ALUOutW   = mw_q.aluout;
    assign ReadDataW = mw_q.readdata;

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: transaction-level model of access latency,
// stalls, bubbles and (with MEM_TIMEOUT_EN) the abort rule.
module tb_memory_stage;

    localparam int DW = 32;
    localparam int AW = 3;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          PCSrcM, RegWriteM, MemWriteM, MemtoRegM;
    logic [DW-1:0] ALUResultM, WriteDataM, mem_rdata;
    logic [AW-1:0] WA3M;
    logic          mem_ready;
    logic          mem_req, mem_we, StallM;
    logic [DW-1:0] mem_addr, mem_wdata, ALUResultMFB;
    logic          PCSrcW, RegWriteW, MemtoRegW, MemErrW;
    logic [DW-1:0] ReadDataW, ALUOutW;
    logic [AW-1:0] WA3W;

    int checks = 0;
    int errors = 0;

    memory_stage #(.DATA_W(DW), .WA_W(AW), .TIMEOUT_CYC(TO)) dut (
        .clk          (clk),
        .reset        (reset),
        .PCSrcM       (PCSrcM),
        .RegWriteM    (RegWriteM),
        .MemWriteM    (MemWriteM),
        .MemtoRegM    (MemtoRegM),
        .ALUResultM   (ALUResultM),
        .WriteDataM   (WriteDataM),
        .WA3M         (WA3M),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_ready    (mem_ready),
        .StallM       (StallM),
        .ALUResultMFB (ALUResultMFB),
        .PCSrcW       (PCSrcW),
        .RegWriteW    (RegWriteW),
        .MemtoRegW    (MemtoRegW),
        .ReadDataW    (ReadDataW),
        .ALUOutW      (ALUOutW),
        .WA3W         (WA3W),
        .MemErrW      (MemErrW)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive_idle();
        PCSrcM     = 1'b0;
        RegWriteM  = 1'b0;
        MemWriteM  = 1'b0;
        MemtoRegM  = 1'b0;
        ALUResultM = '0;
        WriteDataM = '0;
        WA3M       = '0;
        mem_ready  = 1'b0;
        mem_rdata  = '0;
    endtask

    // Called at posedge+1. Memory answers `lat` cycles after the request appears.
    task automatic run_txn(input string name, input logic pc, input logic rw,
                           input logic mw, input logic mr, input logic [DW-1:0] alu,
                           input logic [DW-1:0] wd, input logic [AW-1:0] wa,
                           input int lat, input logic [DW-1:0] rdata);
        logic op, ld, abort;
        int   last;
        logic [70:0] got_w, exp_w;
        op    = mw | mr;
        ld    = mr & ~mw;
        last  = op ? lat : 0;
        abort = 1'b0;
`ifdef MEM_TIMEOUT_EN
        if (op && lat > TO - 1) begin
            last  = TO - 1;
            abort = 1'b1;
        end
`endif
        PCSrcM = pc; RegWriteM = rw; MemWriteM = mw; MemtoRegM = mr;
        ALUResultM = alu; WriteDataM = wd; WA3M = wa;
        for (int k = 0; k <= last; k++) begin
            mem_ready = op ? (k == lat) : 1'($urandom_range(0, 1));
            mem_rdata = (op && k == lat) ? rdata : $urandom;
            @(negedge clk);
            checks++;
            if (mem_req !== op) begin
                errors++;
                $display("FAIL %s mem_req k=%0d: got %b expected %b", name, k, mem_req, op);
            end
            checks++;
            if (StallM !== (op && k < last)) begin
                errors++;
                $display("FAIL %s StallM k=%0d: got %b expected %b", name, k, StallM, op && k < last);
            end
            checks++;
            if (mem_we !== (op & mw)) begin
                errors++;
                $display("FAIL %s mem_we k=%0d: got %b expected %b", name, k, mem_we, op & mw);
            end
            checks++;
            if (ALUResultMFB !== alu) begin
                errors++;
                $display("FAIL %s ALUResultMFB k=%0d: got %h expected %h", name, k, ALUResultMFB, alu);
            end
            if (op) begin
                checks++;
                if (mem_addr !== alu || (mw && mem_wdata !== wd)) begin
                    errors++;
                    $display("FAIL %s mem_addr/wdata k=%0d: got %h/%h expected %h/%h",
                             name, k, mem_addr, mem_wdata, alu, wd);
                end
            end
            @(posedge clk);
            #1;
            if (k < last || abort) begin
                exp_w = '0;
                exp_w[67] = abort && k == last;
                got_w = {PCSrcW, RegWriteW, MemtoRegW, MemErrW, WA3W, ALUOutW, ReadDataW};
            end else begin
                exp_w = {pc, rw, ld, 1'b0, wa, alu, ld ? rdata : 32'h0};
                got_w = {PCSrcW, RegWriteW, MemtoRegW, MemErrW, WA3W, ALUOutW,
                         ld ? ReadDataW : 32'h0};
            end
            checks++;
            if (got_w !== exp_w) begin
                errors++;
                $display("FAIL %s W-bundle k=%0d: got %h expected %h", name, k, got_w, exp_w);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive_idle();
        MemtoRegM = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (mem_req !== 1'b0 || StallM !== 1'b0) begin
                errors++;
                $display("FAIL reset gating: got req=%b stall=%b expected 0/0", mem_req, StallM);
            end
            @(posedge clk);
            #1;
            checks++;
            if ({PCSrcW, RegWriteW, MemtoRegW, MemErrW, WA3W, ALUOutW, ReadDataW} !== 71'h0) begin
                errors++;
                $display("FAIL reset W outputs: got %b%b%b%b %h %h %h expected all 0",
                         PCSrcW, RegWriteW, MemtoRegW, MemErrW, WA3W, ALUOutW, ReadDataW);
            end
        end
        reset = 1'b0;
        drive_idle();
    endtask

    task automatic test_directed();
        run_txn("alu_op", 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0010, 32'h0, 3'd3, 0, 32'h0);
        run_txn("load_wait3", 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0040, 32'h0, 3'd5, 3, 32'hDEAD_BEEF);
        run_txn("store_zero_wait", 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0080, 32'h1234_5678, 3'd0, 0, 32'h0);
        run_txn("store_and_load", 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_00C0, 32'hCAFE_F00D, 3'd7, 2, 32'h5555_AAAA);
    endtask

    task automatic test_reset_in_wait();
        logic [70:0] got_w;
        drive_idle();
        RegWriteM = 1'b1; MemtoRegM = 1'b1; ALUResultM = 32'h100; WA3M = 3'd2;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b0 || StallM !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_wait gating: got req=%b stall=%b expected 0/0", mem_req, StallM);
        end
        @(posedge clk);
        #1;
        got_w = {PCSrcW, RegWriteW, MemtoRegW, MemErrW, WA3W, ALUOutW, ReadDataW};
        checks++;
        if (got_w !== 71'h0) begin
            errors++;
            $display("FAIL reset_in_wait W outputs: got %h expected 0", got_w);
        end
        reset = 1'b0;
        drive_idle();
        mem_ready = 1'b1;
        mem_rdata = 32'hFFFF_0000;
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b0 || StallM !== 1'b0) begin
            errors++;
            $display("FAIL stray_ready req/stall: got %b/%b expected 0/0", mem_req, StallM);
        end
        @(posedge clk);
        #1;
        got_w = {PCSrcW, RegWriteW, MemtoRegW, MemErrW, WA3W, ALUOutW, ReadDataW};
        checks++;
        if (got_w !== 71'h0) begin
            errors++;
            $display("FAIL stray_ready W outputs: got %h expected 0", got_w);
        end
        run_txn("after_reset_store", 1'b0, 1'b0, 1'b1, 1'b0, 32'h44, 32'h99, 3'd1, 0, 32'h0);
    endtask

    task automatic test_long_wait();
        run_txn("wait_boundary", 1'b0, 1'b1, 1'b0, 1'b1, 32'h200, 32'h0, 3'd4, TO - 1, 32'h0BAD_F00D);
        run_txn("wait_long", 1'b0, 1'b1, 1'b0, 1'b1, 32'h204, 32'h0, 3'd6, 10, 32'h1357_9BDF);
        run_txn("post_long_alu", 1'b1, 1'b1, 1'b0, 1'b0, 32'h208, 32'h0, 3'd1, 0, 32'h0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            int kind;
            kind = $urandom_range(0, 3);
            run_txn("random", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    kind[1], kind[0], $urandom, $urandom, 3'($urandom_range(0, 7)),
                    $urandom_range(0, 6), $urandom);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            run_txn("b2b_load", 1'b0, 1'b1, 1'b0, 1'b1, 32'h300 + 32'(i * 4), 32'h0,
                    3'(i), 0, $urandom);
        end
    endtask

    initial begin
        drive_idle();
        reset = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_directed();
        test_reset_in_wait();
        test_long_wait();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
Memory stage of the 5-stage pipelined core. Consumes the E->M pipeline-register outputs (PCSrcM, RegWriteM, MemWriteM, MemtoRegM, ALUResultM, WriteDataM, WA3M). Drives a req/ready data-memory port and requests a pipeline freeze while an access is outstanding. Feeds the M->W pipeline register and supplies the M-stage forwarding value back to execute.

Parameters:
DATA_W, 32, datapath / address width
WA_W, 3, register-file write-address width
TIMEOUT_CYC, 64, wait cycles before abort (only with MEM_TIMEOUT_EN)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
PCSrcM, RegWriteM, MemWriteM, MemtoRegM  in  1 each  control from E->M register
ALUResultM  in  DATA_W  address / ALU result
WriteDataM  in  DATA_W  store data
WA3M  in  WA_W  destination register
mem_req  out  1  access request
mem_we  out  1  1 = store
mem_addr  out  DATA_W  = ALUResultM
mem_wdata  out  DATA_W  = WriteDataM
mem_rdata  in  DATA_W  load data, valid with mem_ready
mem_ready  in  1  access complete this cycle
StallM  out  1  freeze IF/ID/EX and the E->M register
ALUResultMFB  out  DATA_W  forwarding value = ALUResultM (combinational)
PCSrcW, RegWriteW, MemtoRegW  out  1 each  registered control to writeback
ReadDataW, ALUOutW  out  DATA_W  registered load data / ALU result
WA3W  out  WA_W  registered destination
MemErrW  out  1  registered access-abort flag

Behaviour:
- Memory op = MemWriteM | MemtoRegM. If both are set, treat as a store; MemtoRegW is forced 0.
- FSM states: IDLE, WAIT.
- IDLE, no memory op: mem_req=0, StallM=0. The M->W register loads the inputs at the next edge (latency 1).
- IDLE, memory op: mem_req=1 combinationally, mem_we=MemWriteM.
  - mem_ready=1 in the same cycle: zero-wait; StallM=0; M->W loads (ReadDataW<=mem_rdata); stay IDLE.
  - Otherwise: StallM=1; go to WAIT.
- WAIT: mem_req held 1; mem_addr, mem_we and mem_wdata stay stable, because upstream is frozen and the E->M inputs hold.
  - mem_ready=0: StallM=1.
  - mem_ready=1: StallM=0; M->W loads the result; go to IDLE.
- Stall cycles: the M->W register loads a bubble (RegWriteW=0, MemtoRegW=0, PCSrcW=0; other fields don't care, set to 0). No duplicate writebacks.
- mem_ready while mem_req=0 is ignored.
- Reset (synchronous, active-high):
  - FSM goes to IDLE; all W outputs and MemErrW go to 0.
  - mem_req and StallM are gated low while reset=1.
  - Reset during WAIT abandons the access; the memory sees mem_req drop in that cycle.
- ALUResultMFB is purely combinational and is valid while stalled.

Optional Feature:
MEM_TIMEOUT_EN
- Defined: a wait counter clears on entry to WAIT and increments each WAIT cycle without mem_ready. When it reaches TIMEOUT_CYC-1 with no ready:
  - the access is aborted and the FSM goes to IDLE;
  - StallM=0 in that cycle;
  - the M->W register loads a bubble with MemErrW=1 for one cycle.
  - mem_ready arriving in the abort cycle wins: normal completion, no error.
- Undefined: no counter; WAIT persists until mem_ready; MemErrW is tied 0.

Decomposition:
- Package mem_stage_pkg: DATA_W/WA_W default constants, typedef enum logic {IDLE, WAIT} mstate_t, and a typedef struct for the M->W bundle.
- Sub-module RegMW: the M->W pipeline register, with synchronous reset and a bubble input.

Test Plan:
1. Non-memory op (RegWriteM=1, ALUResultM=0x00000010, WA3M=3) -> mem_req=0, StallM=0; next cycle RegWriteW=1, ALUOutW=0x10, WA3W=3.
2. Load addr 0x40, mem_ready held 0 for 3 cycles then 1 with rdata=0xDEADBEEF -> StallM=1 for 3 cycles with bubbles (RegWriteW=0); then ReadDataW=0xDEADBEEF, MemtoRegW=1.
3. Store addr 0x80, data 0x12345678, same-cycle ready -> mem_req=1, mem_we=1, mem_wdata=0x12345678, StallM never asserted.
4. Reset asserted in the 2nd WAIT cycle of a load -> mem_req=0 and StallM=0 immediately; next cycle all W outputs are 0 and FSM=IDLE; a later stray mem_ready is ignored.
5. MEM_TIMEOUT_EN, TIMEOUT_CYC=4, mem_ready never asserted -> StallM high for 3 cycles, then drops; MemErrW=1 for one cycle; RegWriteW=0.
6. MemWriteM=1 and MemtoRegM=1 together -> mem_we=1; after completion MemtoRegW=0.
